// File: rtl/div_share_arbiter.sv
// div_share_arbiter
// Shares one fixed-latency divider core between NUM_REQ requesters.
// Jobs are accepted under round-robin arbitration and issued one per cycle.
// A tag FIFO records which requester owns each job and whether its divisor
// was zero, so results can be returned in issue order on one bus.
// After reset, a flush window discards any divider outputs that belong to
// jobs abandoned by that reset.

module div_share_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int DW           = 16,
    parameter int DIV_LATENCY  = 20,
    parameter int MAX_INFLIGHT = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DW-1:0]         req_dividend,
    input  logic [NUM_REQ*DW-1:0]         req_divisor,
    output logic                          div_dividend_tvalid,
    output logic [DW-1:0]                 div_dividend_tdata,
    output logic                          div_divisor_tvalid,
    output logic [DW-1:0]                 div_divisor_tdata,
    input  logic                          div_dout_tvalid,
    input  logic [2*DW-1:0]               div_dout_tdata,
    output logic                          res_valid,
    output logic [ID_W-1:0]               res_id,
    output logic [DW-1:0]                 res_quotient,
    output logic [DW-1:0]                 res_remainder,
    output logic                          res_div_zero,
    output logic [$clog2(MAX_INFLIGHT):0] inflight,
    output logic                          busy,
    output logic                          tag_err
);

    localparam int PTR_W = $clog2(MAX_INFLIGHT);
    localparam int CNT_W = PTR_W + 1;
    localparam int FL_W  = $clog2(DIV_LATENCY + 2);
    localparam int TAG_W = ID_W + 1;

    localparam logic [FL_W-1:0]  FLUSH_LOAD = FL_W'(DIV_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(MAX_INFLIGHT);

    // Arbitration state
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic [ID_W:0]      cand;

    // Control
    logic stall;
    logic flush_active;
    logic fifo_full;
    logic fifo_empty;
    logic issue;
    logic pop;
    logic stray;

    // Operands of the granted requester
    logic [DW-1:0] sel_dividend;
    logic [DW-1:0] sel_divisor;

    // Issue registers toward the divider
    logic          div_valid_q, div_valid_d;
    logic [DW-1:0] dividend_q, dividend_d;
    logic [DW-1:0] divisor_q, divisor_d;

    // Tag FIFO
    logic [TAG_W-1:0] tag_mem_q [MAX_INFLIGHT];
    logic [TAG_W-1:0] tag_wr;
    logic [TAG_W-1:0] tag_rd;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;

    // Flush window counter
    logic [FL_W-1:0] flush_q, flush_d;

    // Result registers
    logic            res_valid_q, res_valid_d;
    logic [ID_W-1:0] res_id_q, res_id_d;
    logic [DW-1:0]   res_quot_q, res_quot_d;
    logic [DW-1:0]   res_rem_q, res_rem_d;
    logic            res_dz_q, res_dz_d;
    logic            tag_err_q, tag_err_d;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_any && req_valid[cand[ID_W-1:0]]) begin
                grant_any                = 1'b1;
                grant_idx                = cand[ID_W-1:0];
                grant[cand[ID_W-1:0]]    = 1'b1;
            end
        end
    end

    // Select the dividend and divisor of whichever requester holds the grant.
    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_dividend = req_dividend[i*DW +: DW];
                sel_divisor  = req_divisor[i*DW +: DW];
            end
        end
    end

    assign flush_active = (flush_q != '0);
    assign fifo_full    = (inflight_q == CNT_FULL);
    assign fifo_empty   = (inflight_q == '0);
    assign stall        = flush_active | fifo_full;
    assign req_ready    = grant & {NUM_REQ{~stall}};
    assign issue        = grant_any & ~stall;
    assign pop          = div_dout_tvalid & ~flush_active & ~fifo_empty;
    assign stray        = div_dout_tvalid & ~flush_active & fifo_empty;
    assign tag_wr       = {grant_idx, (sel_divisor == '0)};
    assign tag_rd       = tag_mem_q[rd_ptr_q];

    // Next-state for arbitration pointer, issue registers and flush counter.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        div_valid_d = issue;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        flush_d     = flush_q;
        if (issue) begin
            dividend_d = sel_dividend;
            divisor_d  = sel_divisor;
            if (grant_idx == ID_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + ID_W'(1);
            end
        end
        if (flush_active) begin
            flush_d = flush_q - FL_W'(1);
        end
    end

    // Next-state for tag FIFO pointers and the in-flight job count.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = inflight_q;
        if (issue) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({issue, pop})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Next-state for the result bus; a zero divisor overrides the divider data.
    always_comb begin
        res_valid_d = pop;
        res_id_d    = res_id_q;
        res_quot_d  = res_quot_q;
        res_rem_d   = res_rem_q;
        res_dz_d    = res_dz_q;
        tag_err_d   = tag_err_q | stray;
        if (pop) begin
            res_id_d = tag_rd[TAG_W-1:1];
            res_dz_d = tag_rd[0];
            if (tag_rd[0]) begin
                res_quot_d = '1;
                res_rem_d  = '0;
            end else begin
                res_quot_d = div_dout_tdata[2*DW-1:DW];
                res_rem_d  = div_dout_tdata[DW-1:0];
            end
        end
    end

    // State registers; reset abandons in-flight jobs and opens the flush window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            div_valid_q <= 1'b0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            inflight_q  <= '0;
            flush_q     <= FLUSH_LOAD;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_quot_q  <= '0;
            res_rem_q   <= '0;
            res_dz_q    <= 1'b0;
            tag_err_q   <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            div_valid_q <= div_valid_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            inflight_q  <= inflight_d;
            flush_q     <= flush_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_quot_q  <= res_quot_d;
            res_rem_q   <= res_rem_d;
            res_dz_q    <= res_dz_d;
            tag_err_q   <= tag_err_d;
        end
    end

    // Tag storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem_q[wr_ptr_q] <= tag_wr;
        end
    end

    assign div_dividend_tvalid = div_valid_q;
    assign div_divisor_tvalid  = div_valid_q;
    assign div_dividend_tdata  = dividend_q;
    assign div_divisor_tdata   = divisor_q;
    assign res_valid           = res_valid_q;
    assign res_id              = res_id_q;
    assign res_quotient        = res_quot_q;
    assign res_remainder       = res_rem_q;
    assign res_div_zero        = res_dz_q;
    assign inflight            = inflight_q;
    assign busy                = (inflight_q != '0) | flush_active;
    assign tag_err             = tag_err_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Testbench for div_share_arbiter: a divider model with a fixed delay line,
// a queue-based reference model checked every cycle, and directed scenarios
// with hand-computed expectations.

module tb_div_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int DW      = 16;
    localparam int LAT     = 20;
    localparam int MAXF    = 32;
    localparam int CW      = 6;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*DW-1:0] req_dividend = '0;
    logic [NUM_REQ*DW-1:0] req_divisor = '0;
    logic                  div_dividend_tvalid;
    logic [DW-1:0]         div_dividend_tdata;
    logic                  div_divisor_tvalid;
    logic [DW-1:0]         div_divisor_tdata;
    logic                  div_dout_tvalid = 1'b0;
    logic [2*DW-1:0]       div_dout_tdata = '0;
    logic                  res_valid;
    logic [ID_W-1:0]       res_id;
    logic [DW-1:0]         res_quotient;
    logic [DW-1:0]         res_remainder;
    logic                  res_div_zero;
    logic [CW-1:0]         inflight;
    logic                  busy;
    logic                  tag_err;

    div_share_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .DW(DW),
        .DIV_LATENCY(LAT), .MAX_INFLIGHT(MAXF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_dividend(req_dividend),
        .req_divisor(req_divisor),
        .div_dividend_tvalid(div_dividend_tvalid),
        .div_dividend_tdata(div_dividend_tdata),
        .div_divisor_tvalid(div_divisor_tvalid),
        .div_divisor_tdata(div_divisor_tdata),
        .div_dout_tvalid(div_dout_tvalid),
        .div_dout_tdata(div_dout_tdata),
        .res_valid(res_valid),
        .res_id(res_id),
        .res_quotient(res_quotient),
        .res_remainder(res_remainder),
        .res_div_zero(res_div_zero),
        .inflight(inflight),
        .busy(busy),
        .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Divider model: each accepted job emerges LAT cycles later, optionally
    // held back, plus an on-demand strobe with nothing behind it.
    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            due;
    } djob_t;

    djob_t dq[$];
    bit    hold = 1'b0;
    int    release_cnt = 0;
    bit    stray_req = 1'b0;

    initial forever begin
        djob_t j;
        @(posedge clk);
        #1;
        if (div_dividend_tvalid) begin
            j.a   = div_dividend_tdata;
            j.b   = div_divisor_tdata;
            j.due = cyc + LAT;
            dq.push_back(j);
        end
        div_dout_tvalid = 1'b0;
        if (stray_req) begin
            div_dout_tvalid = 1'b1;
            div_dout_tdata  = 32'hDEAD_BEEF;
            stray_req       = 1'b0;
        end else if (dq.size() > 0 && dq[0].due <= cyc && (!hold || release_cnt > 0)) begin
            j = dq.pop_front();
            div_dout_tvalid = 1'b1;
            if (j.b == '0) div_dout_tdata = 32'h1234_5678;
            else           div_dout_tdata = {j.a / j.b, j.a % j.b};
            if (hold) release_cnt--;
        end
    end

    // Reference model: queue of outstanding jobs, round-robin pointer and
    // flush countdown; compared against the DUT on every falling edge.
    typedef struct {
        int            id;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } mjob_t;

    mjob_t         mq[$];
    int            m_rr = 0;
    int            m_flush = 0;
    bit            m_tagerr = 1'b0;
    bit            m_ok = 1'b0;
    bit            m_resv = 1'b0;
    int            m_id = 0;
    logic [DW-1:0] m_q = '0;
    logic [DW-1:0] m_r = '0;
    bit            m_dz = 1'b0;
    bit            m_tv = 1'b0;
    logic [DW-1:0] m_a = '0;
    logic [DW-1:0] m_b = '0;

    initial forever begin
        int                 g;
        int                 idx;
        bit                 stall;
        mjob_t              j;
        logic [NUM_REQ-1:0] exp_ready;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (m_rr + k) % NUM_REQ;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        stall     = (m_flush > 0) || (mq.size() == MAXF);
        exp_ready = '0;
        if (g >= 0 && !stall) exp_ready[g] = 1'b1;
        if (m_ok) begin
            checkOutput("req_ready", req_ready, exp_ready);
            checkOutput("inflight", inflight, mq.size());
            checkOutput("busy", busy, (mq.size() != 0 || m_flush > 0));
            checkOutput("tag_err", tag_err, m_tagerr);
            checkOutput("res_valid", res_valid, m_resv);
            if (m_resv) begin
                checkOutput("res_id", res_id, m_id);
                checkOutput("res_quotient", res_quotient, m_q);
                checkOutput("res_remainder", res_remainder, m_r);
                checkOutput("res_div_zero", res_div_zero, m_dz);
            end
            checkOutput("dividend_tvalid", div_dividend_tvalid, m_tv);
            checkOutput("divisor_tvalid", div_divisor_tvalid, m_tv);
            if (m_tv) begin
                checkOutput("dividend_tdata", div_dividend_tdata, m_a);
                checkOutput("divisor_tdata", div_divisor_tdata, m_b);
            end
        end
        if (!rst_n) begin
            mq.delete();
            m_rr     = 0;
            m_flush  = LAT + 1;
            m_tagerr = 1'b0;
            m_resv   = 1'b0;
            m_tv     = 1'b0;
            m_ok     = 1'b1;
        end else begin
            m_resv = 1'b0;
            if (div_dout_tvalid && m_flush == 0) begin
                if (mq.size() > 0) begin
                    j      = mq.pop_front();
                    m_resv = 1'b1;
                    m_id   = j.id;
                    m_dz   = (j.b == '0);
                    m_q    = m_dz ? 16'hFFFF : j.a / j.b;
                    m_r    = m_dz ? 16'h0000 : j.a % j.b;
                end else begin
                    m_tagerr = 1'b1;
                end
            end
            if (g >= 0 && !stall) begin
                j.id = g;
                j.a  = req_dividend[g*DW +: DW];
                j.b  = req_divisor[g*DW +: DW];
                mq.push_back(j);
                m_rr = (g + 1) % NUM_REQ;
                m_tv = 1'b1;
                m_a  = j.a;
                m_b  = j.b;
            end else begin
                m_tv = 1'b0;
            end
            if (m_flush > 0) m_flush--;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_job(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_dividend[i*DW +: DW] = a;
        req_divisor[i*DW +: DW]  = b;
    endtask

    // Present one job on requester i and return the cycle of its handshake.
    task automatic applyStimulus(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 output int hs_cyc);
        step();
        set_job(i, a, b);
        req_valid[i] = 1'b1;
        hs_cyc = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                hs_cyc = cyc;
                break;
            end
        end
        if (hs_cyc < 0) checkOutput("handshake_timeout", 0, 1);
        step();
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_res(output int rcyc, output logic [ID_W-1:0] id, output logic [DW-1:0] q,
                            output logic [DW-1:0] r, output logic dz);
        rcyc = -1; id = '0; q = '0; r = '0; dz = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (res_valid) begin
                rcyc = cyc; id = res_id; q = res_quotient; r = res_remainder; dz = res_div_zero;
                break;
            end
        end
        if (rcyc < 0) checkOutput("res_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (inflight == '0 && !busy) begin
                idle = 1'b1;
                break;
            end
        end
        checkOutput("idle", idle, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    logic [DW-1:0] sa [4] = '{16'd100, 16'd120, 16'd100, 16'd7};
    logic [DW-1:0] sb [4] = '{16'd50,  16'd3,   16'd3,   16'd4};
    logic [DW-1:0] sq [4] = '{16'd2,   16'd40,  16'd33,  16'd1};
    logic [DW-1:0] sr [4] = '{16'd0,   16'd0,   16'd1,   16'd3};

    initial begin
        int              hc, rc, g, n_hs, peak, zero_cnt, resv_cnt, strobe_cnt;
        int              ids[$];
        logic [ID_W-1:0] rid;
        logic [DW-1:0]   rq, rrem;
        logic            rdz;

        // Reset state
        repeat (3) step();
        @(negedge clk);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_res_id", res_id, 0);
        checkOutput("rst_res_quotient", res_quotient, 0);
        checkOutput("rst_res_remainder", res_remainder, 0);
        checkOutput("rst_res_div_zero", res_div_zero, 0);
        checkOutput("rst_tvalid", {div_dividend_tvalid, div_divisor_tvalid}, 0);
        checkOutput("rst_tdata", {div_dividend_tdata, div_divisor_tdata}, 0);
        checkOutput("rst_inflight", inflight, 0);
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_tag_err", tag_err, 0);
        step();
        rst_n = 1'b1;
        repeat (23) step();

        // Fairness: all four requesters continuously valid
        for (int i = 0; i < NUM_REQ; i++) set_job(i, DW'(1000 + 37 * i), DW'(i + 3));
        req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            g = -1;
            for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) g = k;
            checkOutput("fair_grant", g, c % 4);
            step();
        end
        req_valid = '0;
        peak = 0;
        ids.delete();
        for (int n = 0; n < 80 && ids.size() < 8; n++) begin
            @(negedge clk);
            if (int'(inflight) > peak) peak = int'(inflight);
            if (res_valid) ids.push_back(int'(res_id));
        end
        checkOutput("fair_count", ids.size(), 8);
        for (int k = 0; k < ids.size(); k++) checkOutput("fair_res_id", ids[k], k % 4);
        checkOutput("fair_peak", peak, 8);
        checkOutput("fair_drained", inflight, 0);

        // Single jobs from requester 0
        for (int t = 0; t < 4; t++) begin
            applyStimulus(0, sa[t], sb[t], hc);
            wait_res(rc, rid, rq, rrem, rdz);
            checkOutput("single_latency", rc - hc, 22);
            checkOutput("single_id", rid, 0);
            checkOutput("single_q", rq, sq[t]);
            checkOutput("single_r", rrem, sr[t]);
        end

        // Divide by zero on requester 2
        applyStimulus(2, 16'd55, 16'd0, hc);
        wait_res(rc, rid, rq, rrem, rdz);
        checkOutput("dz_id", rid, 2);
        checkOutput("dz_flag", rdz, 1);
        checkOutput("dz_q", rq, 16'hFFFF);
        checkOutput("dz_r", rrem, 0);

        // Fill the tag FIFO with the divider held
        step();
        hold = 1'b1;
        set_job(1, 16'd500, 16'd7);
        req_valid[1] = 1'b1;
        n_hs = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_ready[1]) n_hs++;
            if (n_hs == MAXF) break;
            step();
        end
        checkOutput("full_issued", n_hs, MAXF);
        step();
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checkOutput("full_ready", req_ready, 0);
            checkOutput("full_inflight", inflight, MAXF);
            step();
        end
        release_cnt = 1;
        strobe_cnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (div_dout_tvalid) begin
                strobe_cnt = 1;
                break;
            end
            step();
        end
        checkOutput("release_strobe", strobe_cnt, 1);
        checkOutput("ready_during_pop", req_ready, 0);
        step();
        @(negedge clk);
        checkOutput("ready_after_pop", req_ready, 4'b0010);
        step();
        req_valid = '0;
        hold = 1'b0;
        step();
        step();
        req_valid[1] = 1'b1;
        @(negedge clk);
        checkOutput("pop_push_cond", {req_ready[1], div_dout_tvalid}, 2'b11);
        checkOutput("inflight_before", inflight, 31);
        step();
        req_valid = '0;
        @(negedge clk);
        checkOutput("inflight_pop_push", inflight, 31);
        wait_idle();

        // Reset with five jobs in flight
        step();
        set_job(3, 16'd900, 16'd11);
        req_valid[3] = 1'b1;
        n_hs = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready[3]) n_hs++;
            if (n_hs == 5) break;
            step();
        end
        checkOutput("mid_issued", n_hs, 5);
        step();
        req_valid = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_job(i, DW'(300 + i), DW'(5));
        req_valid = '1;
        zero_cnt = 0; resv_cnt = 0; strobe_cnt = 0;
        for (int c = 0; c < 21; c++) begin
            @(negedge clk);
            if (req_ready == '0) zero_cnt++;
            if (res_valid) resv_cnt++;
            if (div_dout_tvalid) strobe_cnt++;
            step();
        end
        @(negedge clk);
        checkOutput("flush_ready_low_cycles", zero_cnt, 21);
        checkOutput("flush_no_result", resv_cnt, 0);
        checkOutput("flush_strobes", strobe_cnt, 5);
        checkOutput("flush_tag_err", tag_err, 0);
        checkOutput("ready_after_flush", req_ready != '0, 1);
        checkOutput("busy_after_flush", busy, 0);
        step();
        req_valid = '0;
        wait_idle();

        // Stray divider output with nothing in flight
        step();
        stray_req = 1'b1;
        strobe_cnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (div_dout_tvalid) begin
                strobe_cnt = 1;
                break;
            end
        end
        checkOutput("stray_strobe", strobe_cnt, 1);
        checkOutput("stray_before", tag_err, 0);
        step();
        @(negedge clk);
        checkOutput("stray_tag_err", tag_err, 1);
        checkOutput("stray_no_result", res_valid, 0);
        for (int n = 0; n < 5; n++) begin
            step();
            @(negedge clk);
            checkOutput("stray_sticky", tag_err, 1);
        end
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("stray_cleared", tag_err, 0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_share_arbiter.md
# div_share_arbiter

Shares one fixed-latency 16-bit integer divider core between NUM_REQ requesters in the CNN datapath, such as the average-pool normaliser and the quantisation scaler. It accepts divide jobs from the requesters under round-robin arbitration and issues at most one job per cycle to the divider's AXI-stream inputs. Each result is tagged with its requester ID and returned on a shared result bus. It also flags divide-by-zero and drops stray divider outputs after reset.

## Interface

Parameters:

- NUM_REQ, 4: number of requesters (2..8).
- ID_W, 2: requester ID width; equals clog2(NUM_REQ), minimum 1.
- DW, 16: dividend, divisor, quotient and remainder width.
- DIV_LATENCY, 20: divider cycles from input tvalid to m_axis_dout_tvalid. The value is fixed and constant.
- MAX_INFLIGHT, 32: tag FIFO depth. Must be a power of 2 and at least DIV_LATENCY+2.

Ports:

- clk, in, 1: single clock; all logic is on the rising edge.
- rst_n, in, 1: reset, synchronous and active-low.
- req_valid, in, NUM_REQ: per-requester job valid.
- req_ready, out, NUM_REQ: per-requester accept; at most one bit is high.
- req_dividend, in, NUM_REQ*DW: dividends; requester i uses bits [i*DW +: DW].
- req_divisor, in, NUM_REQ*DW: divisors, same packing.
- div_dividend_tvalid, out, 1: to divider s_axis_dividend_tvalid.
- div_dividend_tdata, out, DW: to divider s_axis_dividend_tdata.
- div_divisor_tvalid, out, 1: to divider s_axis_divisor_tvalid.
- div_divisor_tdata, out, DW: to divider s_axis_divisor_tdata.
- div_dout_tvalid, in, 1: from divider m_axis_dout_tvalid.
- div_dout_tdata, in, 2*DW: from divider; [2*DW-1:DW] is the quotient, [DW-1:0] is the remainder.
- res_valid, out, 1: one-cycle result strobe. There is no backpressure; requesters must sink it.
- res_id, out, ID_W: index of the requester that owns the result.
- res_quotient, out, DW: quotient.
- res_remainder, out, DW: remainder.
- res_div_zero, out, 1: the job's divisor was 0.
- inflight, out, clog2(MAX_INFLIGHT)+1: number of jobs issued but not yet returned.
- busy, out, 1: high when inflight != 0 or the flush window is active.
- tag_err, out, 1: sticky flag; set when a divider output arrives with the tag FIFO empty outside the flush window.

## Operation

- **Arbitration.** Round-robin pointer rr_ptr (reset 0).
  - Grant the first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around.
  - req_ready is combinational: req_ready[i] = grant[i] & ~stall.
  - stall = flush_active | (inflight == MAX_INFLIGHT).
  - On handshake (req_valid[i] & req_ready[i]), rr_ptr becomes (i+1) mod NUM_REQ. It is unchanged when there is no handshake.
- **Issue.** On handshake, in the next cycle:
  - both div_*_tvalid = 1;
  - div_dividend_tdata and div_divisor_tdata are registered from requester i;
  - the tag {i, divisor==0} is pushed into the tag FIFO.
  - With no handshake, both div_*_tvalid = 0. The tdata registers hold their last value.
- **Return.** On div_dout_tvalid with the FIFO non-empty, pop the tag. In the next cycle:
  - res_valid = 1 and res_id = tag ID;
  - res_quotient and res_remainder come from the dout slices;
  - res_div_zero = tag zero flag;
  - if the zero flag is set, res_quotient is forced to all ones and res_remainder to 0, whatever the divider output.
- **Ordering.** Results return in issue order, not per requester.
- **Inflight counter.**
  - +1 on issue, −1 on pop; unchanged if both happen in the same cycle.
  - A full FIFO blocks issue. A pop in the same cycle as full frees a slot from the next cycle onward.
- **Flush.**
  - Reset loads the flush counter with DIV_LATENCY+1. While it is nonzero, flush_active = 1 and all div_dout_tvalid strobes are discarded without setting tag_err.
  - Reset asserted mid-operation abandons all in-flight jobs. The FIFO is cleared and no res_valid is produced for those jobs.
- **tag_err.** Cleared only by reset. A strobe that sets tag_err produces no res_valid.

## Timing

- Reset values:
  - res_valid=0, res_id=0, res_quotient=0, res_remainder=0, res_div_zero=0;
  - div_*_tvalid=0, div_*_tdata=0;
  - inflight=0, tag_err=0, rr_ptr=0;
  - busy=1 (flush window active);
  - req_ready=0 for DIV_LATENCY+1 cycles after rst_n rises.
- Latency: a handshake in cycle T gives div_*_tvalid in T+1, div_dout_tvalid in T+1+DIV_LATENCY, and res_valid in T+2+DIV_LATENCY.
- Throughput: one job per cycle sustained when any requester is valid.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,3,0…

## Test plan

- **Single jobs.** Requester 0 issues 100/50, then 120/3, 100/3 and 7/4 on four separate handshakes, DIV_LATENCY=20. Required: res_valid exactly 22 cycles after each handshake, with (q,r) = (2,0), (40,0), (33,1), (1,3), res_id=0.
- **Fairness.** All four requesters are held valid for 8 cycles. Required: grant order 0,1,2,3,0,1,2,3; the res_id sequence matches that order; inflight peaks at 8 and returns to 0.
- **Divide by zero.** Requester 2 issues 55/0. Required: res_id=2, res_div_zero=1, quotient 16'hFFFF, remainder 0.
- **Back-to-back and full.** With MAX_INFLIGHT=32, the divider model is stalled (strobes withheld) and 32 jobs are issued. Required:
  - after the 32nd, req_ready stays 0;
  - releasing one div_dout_tvalid re-enables req_ready the next cycle;
  - a pop in the same cycle as an issue leaves inflight unchanged.
- **Reset mid-operation.** rst_n is pulsed low with 5 jobs in flight, and the model still emits 5 strobes within 21 cycles. Required: no res_valid, tag_err stays 0, req_ready is 0 for 21 cycles, and busy falls afterwards.
- **Stray output.** After the flush window, div_dout_tvalid is pulsed with nothing in flight. Required: tag_err=1 and held until reset, no res_valid.
